// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad scanner, debouncer and operand-entry FSM for a two-operand calculator
// Ports: clk/reset (sync, active-high); row_sel scans keypad rows; key_valid/key_code come from
//   the key encoder; op_sel/start request an operation; wr_en/wr_addr/wr_data write the register
//   bank; rd_addr_a/rd_addr_b are fixed at R0/R1; alu_op selects the ALU function and
//   alu_result/alu_zero return from it; result/zero hold the last write-back; busy/done report progress.
module calc_sequencer #(
    parameter int SCAN_DIV = 16,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic [1:0] row_sel,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic [1:0] op_sel,
    input  logic       start,
    output logic       wr_en,
    output logic [1:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [1:0] rd_addr_a,
    output logic [1:0] rd_addr_b,
    output logic [1:0] alu_op,
    input  logic [7:0] alu_result,
    input  logic       alu_zero,
    output logic [7:0] result,
    output logic       zero,
    output logic       busy,
    output logic       done
);
    localparam int SW = $clog2(SCAN_DIV + 1);
    localparam int DW = $clog2(DEBOUNCE + 1);
    typedef enum logic [2:0] {IDLE, GET_A, GET_B, READY, EXEC, WB, DONE} state_t;
    state_t state_q;
    logic [SW-1:0] scan_q, scan_d;
    logic [1:0] row_q, row_d;
    logic [DW-1:0] dcnt_q, dcnt_d, cnt_inc;
    logic [3:0] dcode_q, dcode_d, hi_q;
    logic held_q, held_d, pend_q, same, press, deb_idle, digit, clear;
    logic wr_en_q, zero_q, busy_q, done_q;
    logic [1:0] wr_addr_q, alu_op_q;
    logic [7:0] wr_data_q, result_q;
    assign cnt_inc = dcnt_q + 1'b1;
    assign same = key_valid && dcnt_q != '0 && key_code == dcode_q;
    assign press = !held_q && key_valid && (same ? cnt_inc : DW'(1)) == DW'(DEBOUNCE);
    assign digit = press && key_code != 4'hF;
    assign clear = press && key_code == 4'hF;
    // Scanning only advances when nothing is being qualified, held or even hinted at.
    assign deb_idle = !held_q && dcnt_q == '0 && !key_valid;
    always_comb begin
        held_d = held_q;
        dcnt_d = dcnt_q;
        dcode_d = dcode_q;
        if (held_q) begin
            held_d = key_valid || cnt_inc != DW'(DEBOUNCE);
            dcnt_d = (key_valid || !held_d) ? '0 : cnt_inc;
        end else if (press) begin
            held_d = 1'b1;
            dcnt_d = '0;
        end else begin
            dcnt_d = key_valid ? (same ? cnt_inc : DW'(1)) : '0;
            dcode_d = key_valid ? key_code : dcode_q;
        end
        scan_d = deb_idle ? (scan_q == SW'(SCAN_DIV - 1) ? '0 : scan_q + 1'b1) : scan_q;
        row_d = row_q + 2'(deb_idle && scan_q == SW'(SCAN_DIV - 1));
    end
    // Reset leaves the debouncer in the held state so a key still down must be released first.
    always_ff @(posedge clk) begin
        if (reset) begin
            held_q <= 1'b1;
            dcnt_q <= '0;
            dcode_q <= '0;
            scan_q <= '0;
            row_q <= '0;
        end else begin
            held_q <= held_d;
            dcnt_q <= dcnt_d;
            dcode_q <= dcode_d;
            scan_q <= scan_d;
            row_q <= row_d;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hi_q <= '0;
            pend_q <= 1'b0;
            wr_en_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            alu_op_q <= '0;
            result_q <= '0;
            zero_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            if (clear && state_q inside {IDLE, GET_A, GET_B, READY}) begin
                state_q <= IDLE;
                hi_q <= '0;
                pend_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (digit) begin
                        hi_q <= key_code;
                        state_q <= GET_A;
                    end
                    GET_A: if (digit) begin
                        wr_en_q <= 1'b1;
                        wr_addr_q <= 2'd0;
                        wr_data_q <= {hi_q, key_code};
                        state_q <= GET_B;
                    end
                    GET_B: if (digit) begin
                        hi_q <= key_code;
                        pend_q <= !pend_q;
                        if (pend_q) begin
                            wr_en_q <= 1'b1;
                            wr_addr_q <= 2'd1;
                            wr_data_q <= {hi_q, key_code};
                            state_q <= READY;
                        end
                    end
                    READY: if (start) begin
                        alu_op_q <= op_sel;
                        busy_q <= 1'b1;
                        state_q <= EXEC;
                    end
                    // The ALU reads R0/R1 combinationally; its output is captured on leaving EXEC.
                    EXEC: begin
                        wr_en_q <= 1'b1;
                        wr_addr_q <= 2'd2;
                        wr_data_q <= alu_result;
                        result_q <= alu_result;
                        zero_q <= alu_zero;
                        state_q <= WB;
                    end
                    WB: begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state_q <= DONE;
                    end
                    DONE: begin
                        done_q <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
    assign row_sel = row_q;
    assign wr_en = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign rd_addr_a = 2'd0;
    assign rd_addr_b = 2'd1;
    assign alu_op = alu_op_q;
    assign result = result_q;
    assign zero = zero_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: randomized self-checking bench with register bank, ALU and digit-level model
module tb_calc_sequencer;
    localparam int SD = 16;
    localparam int DB = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0] row_sel, wr_addr, rd_addr_a, rd_addr_b, alu_op;
    logic key_valid = 1'b0;
    logic [3:0] key_code = '0;
    logic [1:0] op_sel = '0;
    logic start = 1'b0;
    logic wr_en, zero, busy, done, alu_zero;
    logic [7:0] wr_data, alu_result, result;
    logic [7:0] bank [4];
    logic prev_we = 1'b0;
    logic [9:0] wq[$];
    logic [9:0] expq[$];
    logic [3:0] md[$];
    logic mready = 1'b0;
    logic [7:0] ma = '0, mb = '0;
    int checks = 0;
    int passed = 0;
    calc_sequencer #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .clk(clk), .reset(reset), .row_sel(row_sel), .key_valid(key_valid), .key_code(key_code),
        .op_sel(op_sel), .start(start), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .alu_op(alu_op), .alu_result(alu_result),
        .alu_zero(alu_zero), .result(result), .zero(zero), .busy(busy), .done(done)
    );
    always #5 clk = ~clk;
    function automatic logic [7:0] alu_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        return op == 2'd0 ? a + b : op == 2'd1 ? a - b : op == 2'd2 ? a & b : a ^ b;
    endfunction
    assign alu_result = alu_f(alu_op, bank[0], bank[1]);
    assign alu_zero = alu_result == 8'd0;
    always @(posedge clk) begin
        if (reset) begin
            bank <= '{default: 8'd0};
        end else if (wr_en) begin
            bank[wr_addr] <= wr_data;
            wq.push_back({wr_addr, wr_data});
            checks++;
            if (prev_we) $display("FAIL wr_en_back_to_back: got two consecutive writes, required isolated pulses");
            else passed++;
        end
        prev_we <= wr_en;
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle(input int n);
        key_valid = 1'b0;
        repeat (n) tick();
    endtask
    task automatic press(input logic [3:0] c, input int h, input int r);
        key_valid = 1'b1;
        key_code = c;
        repeat (h) tick();
        key_valid = 1'b0;
        repeat (r) tick();
    endtask
    // Model works on the digit stream: every 2nd digit completes an operand byte.
    task automatic key(input logic [3:0] c);
        press(c, $urandom_range(DB, DB + 3), $urandom_range(DB, DB + 3));
        if (c == 4'hF) begin
            md.delete();
            mready = 1'b0;
        end else if (!mready) begin
            md.push_back(c);
            if (md.size() == 2) begin
                ma = {md[0], md[1]};
                expq.push_back({2'd0, ma});
            end
            if (md.size() == 4) begin
                mb = {md[2], md[3]};
                expq.push_back({2'd1, mb});
                mready = 1'b1;
                md.delete();
            end
        end
    endtask
    task automatic clr_model();
        wq.delete();
        expq.delete();
        md.delete();
        mready = 1'b0;
    endtask
    task automatic do_exec(input logic [1:0] op, input string nm);
        logic [7:0] e;
        e = alu_f(op, ma, mb);
        op_sel = op;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({busy, wr_en, done, alu_op} !== {1'b1, 1'b0, 1'b0, op})
            $display("FAIL %s_exec: got busy/we/done/op %b%b%b/%0d required 100/%0d", nm, busy, wr_en, done, alu_op, op);
        else passed++;
        tick();
        checks++;
        if ({busy, wr_en, wr_addr, wr_data, result, zero, done} !== {1'b1, 1'b1, 2'd2, e, e, e == 8'd0, 1'b0})
            $display("FAIL %s_wb: got we=%b addr=%0d data=%h result=%h zero=%b required we=1 addr=2 data=%h result=%h zero=%b",
                     nm, wr_en, wr_addr, wr_data, result, zero, e, e, e == 8'd0);
        else passed++;
        tick();
        checks++;
        if ({done, busy, wr_en} !== 3'b100)
            $display("FAIL %s_done: got done/busy/we %b%b%b required 100", nm, done, busy, wr_en);
        else passed++;
        tick();
        checks++;
        if ({done, busy, result, zero, alu_op} !== {2'b00, e, e == 8'd0, op})
            $display("FAIL %s_hold: got done=%b result=%h op=%0d required done=0 result=%h op=%0d", nm, done, result, alu_op, e, op);
        else passed++;
        mready = 1'b0;
    endtask
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        checks++;
        if ({row_sel, wr_en, wr_addr, wr_data, alu_op, result, zero, busy, done} !== '0)
            $display("FAIL reset_outputs: got nonzero outputs row=%0d we=%b data=%h result=%h busy=%b done=%b required all zero",
                     row_sel, wr_en, wr_data, result, busy, done);
        else passed++;
        checks++;
        if ({rd_addr_a, rd_addr_b} !== 4'b0001)
            $display("FAIL rd_addr: got %0d/%0d required 0/1", rd_addr_a, rd_addr_b);
        else passed++;
        reset = 1'b0;
        idle(DB + 1);
        for (int i = 0; i < 2; i++) begin
            logic [1:0] r;
            r = row_sel;
            repeat (SD) tick();
            checks++;
            if (row_sel !== r + 2'd1) $display("FAIL row_step: got %0d required %0d", row_sel, r + 2'd1);
            else passed++;
        end
    endtask
    task automatic test_entry();
        clr_model();
        key(4'h3); key(4'hC); key(4'h0); key(4'h5);
        checks++;
        if (wq.size() !== 2 || wq[0] !== {2'd0, 8'h3C} || wq[1] !== {2'd1, 8'h05})
            $display("FAIL entry_writes: got %0d writes first %h required 2 writes 03c,105", wq.size(), wq.size() > 0 ? wq[0] : 10'h0);
        else passed++;
        do_exec(2'b01, "fixed");
    endtask
    task automatic test_exec();
        for (int i = 0; i < 6; i++) begin
            logic [3:0] d [4];
            logic [1:0] op;
            clr_model();
            foreach (d[j]) d[j] = 4'($urandom_range(0, 14));
            op = 2'($urandom_range(0, 3));
            if (i == 0) begin
                d[2] = d[0];
                d[3] = d[1];
                op = 2'd1;
            end
            foreach (d[j]) key(d[j]);
            checks++;
            if (wq.size() !== expq.size()) $display("FAIL exec_write_count: got %0d required %0d", wq.size(), expq.size());
            else passed++;
            for (int j = 0; j < expq.size() && j < wq.size(); j++) begin
                checks++;
                if (wq[j] !== expq[j]) $display("FAIL exec_write: got %h required %h", wq[j], expq[j]);
                else passed++;
            end
            do_exec(op, "rand");
        end
    endtask
    task automatic test_glitch();
        logic [1:0] r;
        clr_model();
        idle(2);
        r = row_sel;
        key_valid = 1'b1;
        key_code = 4'h9;
        repeat (DB - 1) tick();
        checks++;
        if (row_sel !== r) $display("FAIL glitch_freeze: got row %0d required %0d", row_sel, r);
        else passed++;
        idle(1);
        r = row_sel;
        repeat (SD) tick();
        checks++;
        if (row_sel !== r + 2'd1) $display("FAIL glitch_resume: got row %0d required %0d", row_sel, r + 2'd1);
        else passed++;
        key(4'h1); key(4'h2);
        checks++;
        if (wq.size() !== 1 || wq[0] !== {2'd0, 8'h12})
            $display("FAIL glitch_write: got %0d writes first %h required 1 write 012", wq.size(), wq.size() > 0 ? wq[0] : 10'h0);
        else passed++;
        key(4'hF);
    endtask
    task automatic test_clear();
        clr_model();
        key(4'h7); key(4'hF); key(4'h1); key(4'h2);
        checks++;
        if (wq.size() !== 1 || wq[0] !== {2'd0, 8'h12})
            $display("FAIL clear_write: got %0d writes first %h required 1 write 012", wq.size(), wq.size() > 0 ? wq[0] : 10'h0);
        else passed++;
        key(4'hF);
    endtask
    task automatic test_random_keys();
        clr_model();
        for (int i = 0; i < 14; i++) key($urandom_range(0, 4) == 0 ? 4'hF : 4'($urandom_range(0, 14)));
        checks++;
        if (wq.size() !== expq.size()) $display("FAIL random_write_count: got %0d required %0d", wq.size(), expq.size());
        else passed++;
        for (int j = 0; j < expq.size() && j < wq.size(); j++) begin
            checks++;
            if (wq[j] !== expq[j]) $display("FAIL random_write: got %h required %h", wq[j], expq[j]);
            else passed++;
        end
        if (mready) do_exec(2'($urandom_range(0, 3)), "random");
        else key(4'hF);
    endtask
    task automatic test_start_ignored();
        clr_model();
        start = 1'b1;
        repeat (4) begin
            tick();
            checks++;
            if (busy !== 1'b0) $display("FAIL start_idle: got busy %b required 0", busy);
            else passed++;
        end
        start = 1'b0;
        key(4'hA); key(4'h6);
        start = 1'b1;
        repeat (4) begin
            tick();
            checks++;
            if (busy !== 1'b0) $display("FAIL start_getb: got busy %b required 0", busy);
            else passed++;
        end
        start = 1'b0;
        key(4'h2); key(4'hB);
        checks++;
        if (wq.size() !== 2 || wq[1] !== {2'd1, 8'h2B})
            $display("FAIL start_writes: got %0d writes required 2 ending 12b", wq.size());
        else passed++;
        do_exec(2'd0, "after_ignore");
    endtask
    task automatic test_busy_keys();
        clr_model();
        key(4'h8); key(4'h1); key(4'h4); key(4'h4);
        wq.delete();
        key_valid = 1'b1;
        key_code = 4'h9;
        op_sel = 2'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        checks++;
        if (done !== 1'b1) $display("FAIL busy_key_done: got done %b required 1", done);
        else passed++;
        repeat (DB) tick();
        idle(DB + 1);
        mready = 1'b0;
        wq.delete();
        key(4'h1); key(4'h2);
        checks++;
        if (wq.size() !== 1 || wq[0] !== {2'd0, 8'h12})
            $display("FAIL busy_key_discard: got %0d writes first %h required 1 write 012", wq.size(), wq.size() > 0 ? wq[0] : 10'h0);
        else passed++;
        key(4'hF);
    endtask
    task automatic test_reset_exec();
        clr_model();
        key(4'h5); key(4'h5); key(4'h2); key(4'h2);
        wq.delete();
        op_sel = 2'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) $display("FAIL rst_exec_busy: got %b required 1", busy);
        else passed++;
        reset = 1'b1;
        tick();
        checks++;
        if ({row_sel, wr_en, wr_addr, wr_data, alu_op, result, zero, busy, done} !== '0)
            $display("FAIL rst_exec_outputs: got we=%b data=%h op=%0d result=%h busy=%b done=%b required all zero",
                     wr_en, wr_data, alu_op, result, busy, done);
        else passed++;
        reset = 1'b0;
        repeat (6) begin
            tick();
            checks++;
            if ({wr_en, done} !== 2'b00) $display("FAIL rst_exec_quiet: got we/done %b%b required 00", wr_en, done);
            else passed++;
        end
        checks++;
        if (wq.size() !== 0) $display("FAIL rst_exec_nowrite: got %0d writes required 0", wq.size());
        else passed++;
        idle(DB + 1);
    endtask
    initial begin
        test_reset();
        test_entry();
        test_exec();
        test_glitch();
        test_clear();
        test_random_keys();
        test_start_ignored();
        test_busy_keys();
        test_reset_exec();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 Parameter SCAN_DIV, default 16: clk cycles per keypad row step while no key is held.
REQ-002 Parameter DEBOUNCE, default 4: consecutive stable cycles required for key press or release.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 row_sel  out  2  keypad row index driven to the key encoder.
REQ-006 key_valid  in  1  encoder reports a key on the current row.
REQ-007 key_code  in  4  encoder hex code; 4'hF = CLEAR, 4'h0-4'hE = digit.
REQ-008 op_sel  in  2  ALU operation requested by the user.
REQ-009 start  in  1  level; execute request.
REQ-010 wr_en  out  1  register bank write strobe, one cycle.
REQ-011 wr_addr  out  2  register bank write address.
REQ-012 wr_data  out  8  register bank write data.
REQ-013 rd_addr_a, rd_addr_b  out  2 each  register bank read addresses, constant 2'd0 and 2'd1.
REQ-014 alu_op  out  2  ALU select.
REQ-015 alu_result  in  8  ALU output, combinational from the register bank read ports.
REQ-016 alu_zero  in  1  ALU zero flag.
REQ-017 result  out  8  last written-back result.
REQ-018 zero  out  1  alu_zero captured at write-back.
REQ-019 busy  out  1  high in EXEC and WB.
REQ-020 done  out  1  one-cycle pulse in DONE.

Function
REQ-021 row_sel SHALL increment mod 4 every SCAN_DIV cycles while the debouncer is idle; it SHALL freeze while a press is being qualified or held.
REQ-022 A press SHALL be accepted only after key_valid=1 with an unchanged key_code for DEBOUNCE consecutive cycles; any change restarts the count.
REQ-023 After acceptance, no further press SHALL be accepted until key_valid=0 for DEBOUNCE consecutive cycles.
REQ-024 FSM states SHALL be IDLE, GET_A, GET_B, READY, EXEC, WB, DONE.
REQ-025 IDLE: on the first accepted digit, load it as the high nibble of operand and go to GET_A.
REQ-026 GET_A: on the next accepted digit, form {hi,lo}, assert wr_en with wr_addr=0, wr_data=byte for one cycle, go to GET_B (high nibble pending).
REQ-027 GET_B: two digits are accepted; on the second, write the byte to wr_addr=1, then go to READY.
REQ-028 READY: start=1 SHALL latch op_sel into alu_op and go to EXEC; start in any other state SHALL be ignored.
REQ-029 EXEC: exactly one cycle; alu_result and alu_zero are sampled at its end.
REQ-030 WB: wr_en=1, wr_addr=2, wr_data=sampled result; result and zero update on the same edge.
REQ-031 DONE: done=1 for one cycle, then go to IDLE; alu_op, result and zero are retained.
REQ-032 Latency from the start-sampling edge to the done pulse SHALL be 3 cycles (EXEC, WB, DONE).
REQ-033 An accepted CLEAR in IDLE, GET_A, GET_B or READY SHALL return to IDLE, discard the pending nibble and issue no write.
REQ-034 Key presses accepted during EXEC, WB or DONE SHALL be discarded, including CLEAR.
REQ-035 wr_en SHALL never be high for two consecutive cycles; at most one write per cycle.

Reset
REQ-036 reset=1 SHALL, on the next edge and from any state, force: state IDLE, row_sel=0, wr_en=0, wr_addr=0, wr_data=0, alu_op=0, result=0, zero=0, busy=0, done=0, and clear the debounce counters and the pending nibble.
REQ-037 Reset mid-operation SHALL abort without a partial write; the held key must be released and re-pressed to be accepted.

Verification
REQ-038 Keys 3,C then 0,5 (each held 6 cycles, released 6) -> writes R0=8'h3C then R1=8'h05, FSM in READY.
REQ-039 In READY, op_sel=2'b01 and a start pulse -> busy for 2 cycles, wr R2=alu_result, done 3 cycles after start, result matches the ALU.
REQ-040 key_valid glitches high for DEBOUNCE-1 cycles -> no acceptance, row_sel resumes stepping.
REQ-041 Key 7, then CLEAR, then keys 1,2 -> first write is R0=8'h12; no write carrying 7.
REQ-042 reset asserted during EXEC -> next cycle all outputs at reset values; no wr_en, no done.
REQ-043 start asserted in IDLE or GET_B -> ignored, busy stays 0.
